ps2_key_event_sequencer: RTL and testbench

- Sits between `PS2_Controller` (`received_data` / `received_data_en`) and the benchmark game logic.
- Parses the PS/2 set-2 scan-code byte stream (E0 extended prefix, F0 break prefix) into whole key events.
- Tracks held state for four game keys and suppresses typematic repeats on them.
- Queues events in a small FIFO with a valid/ready handshake so a slow game FSM never loses a keystroke.

---
 rtl/ps2_key_event_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_key_event_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_sequencer.sv
// Purpose: turns the PS/2 set-2 byte stream into whole key events, tracks four game keys, queues events.
// Latency: a byte strobed in cycle t is visible at the FIFO head (evt_valid) in cycle t+1 if the queue was empty.
// Backpressure: evt_valid/evt_ready handshake; an event arriving while the queue is full and not popping is dropped and flags overflow.
module ps2_key_event_sequencer #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 2_500_000,
    parameter logic [7:0]  KEY0_CODE      = 8'h1D,
    parameter logic [7:0]  KEY1_CODE      = 8'h1C,
    parameter logic [7:0]  KEY2_CODE      = 8'h1B,
    parameter logic [7:0]  KEY3_CODE      = 8'h23
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  received_data,
    input  logic        received_data_en,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic        evt_extended,
    output logic        evt_break,
    output logic [3:0]  key_held,
    output logic [3:0]  key_pressed_pulse,
    output logic        overflow,
    output logic        protocol_error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]      held_q, held_d;
    logic [3:0]      pulse_q, pulse_d;
    logic            ovf_q, ovf_d;
    logic            perr_q, perr_d;
    evt_t            mem_q [FIFO_DEPTH];
    evt_t            mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            is_filler;
    logic            to_expire;
    logic            dec_vld;
    evt_t            dec_evt;
    logic            perr_set;
    logic [3:0]      trk_hit;
    logic            push;
    logic            pop;
    logic            full;
    logic            push_ok;
    evt_t            head;

    // Bytes the keyboard sends that never form a key event on their own.
    assign is_filler = received_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};

    // A prefix left waiting too long is abandoned; a byte arriving in that same cycle takes priority.
    assign to_expire = !received_data_en && (state_q != S_IDLE) && (to_cnt_q == TO_LAST);

    // Prefix decoder: next state, decoded event and protocol error detection.
    always_comb begin
        state_d      = state_q;
        dec_vld      = 1'b0;
        dec_evt.ext  = 1'b0;
        dec_evt.brk  = 1'b0;
        dec_evt.code = received_data;
        perr_set     = 1'b0;
        if (received_data_en) begin
            case (state_q)
                S_IDLE: begin
                    if (received_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (received_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (!is_filler) begin
                        dec_vld = 1'b1;
                    end
                end
                S_EXT: begin
                    if (received_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (received_data == 8'hE0) begin
                        perr_set = 1'b1;
                    end else begin
                        dec_vld     = 1'b1;
                        dec_evt.ext = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (received_data == 8'hE0 || received_data == 8'hF0) begin
                        perr_set = 1'b1;
                    end else begin
                        dec_vld     = 1'b1;
                        dec_evt.brk = 1'b1;
                    end
                end
                S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (received_data == 8'hE0 || received_data == 8'hF0) begin
                        perr_set = 1'b1;
                    end else begin
                        dec_vld     = 1'b1;
                        dec_evt.ext = 1'b1;
                        dec_evt.brk = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (to_expire) begin
            state_d  = S_IDLE;
            perr_set = 1'b1;
        end
    end

    // Timeout counter runs only while a prefix is pending and restarts on every byte.
    always_comb begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (received_data_en || state_q == S_IDLE || to_expire) begin
            to_cnt_d = '0;
        end
    end

    // Extended codes never alias a tracked key even if the low byte matches.
    assign trk_hit[0] = dec_vld && !dec_evt.ext && (dec_evt.code == KEY0_CODE);
    assign trk_hit[1] = dec_vld && !dec_evt.ext && (dec_evt.code == KEY1_CODE);
    assign trk_hit[2] = dec_vld && !dec_evt.ext && (dec_evt.code == KEY2_CODE);
    assign trk_hit[3] = dec_vld && !dec_evt.ext && (dec_evt.code == KEY3_CODE);

    // Held-key tracking: fresh press pulses and enqueues, typematic repeats are swallowed.
    always_comb begin
        held_d  = held_q;
        pulse_d = '0;
        push    = dec_vld;
        for (int n = 0; n < 4; n++) begin
            if (trk_hit[n]) begin
                if (dec_evt.brk) begin
                    held_d[n] = 1'b0;
                end else if (held_q[n]) begin
                    push = 1'b0;
                end else begin
                    held_d[n]  = 1'b1;
                    pulse_d[n] = 1'b1;
                end
            end
        end
    end

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (count_q == DEPTH_CNT);
    assign push_ok   = push && (!full || pop);

    // Event queue bookkeeping; a pop in the same cycle frees room for a push into a full queue.
    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = dec_evt;
        end
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q | (push && full && !pop);
        perr_d   = perr_q | perr_set;
    end

    // State register; reset overrides every input in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            to_cnt_q <= '0;
            held_q   <= '0;
            pulse_q  <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            held_q   <= held_d;
            pulse_q  <= pulse_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head fields read as zero when the queue is empty so stale entries never leak out.
    assign head              = mem_q[rd_ptr_q];
    assign evt_code          = evt_valid ? head.code : 8'h00;
    assign evt_extended      = evt_valid & head.ext;
    assign evt_break         = evt_valid & head.brk;
    assign key_held          = held_q;
    assign key_pressed_pulse = pulse_q;
    assign overflow          = ovf_q;
    assign protocol_error    = perr_q;

endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// Bench for ps2_key_event_sequencer: directed scenarios with literal expectations plus randomized traffic.
// A queue-based reference model predicts every output each cycle; accepted events are logged for literal checks.
// Inputs change on the falling edge, outputs are compared on the next falling edge.
module tb_ps2_key_event_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] dat = 8'h00;

    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_extended;
    logic       evt_break;
    logic [3:0] key_held;
    logic [3:0] key_pressed_pulse;
    logic       overflow;
    logic       protocol_error;

    always #5 clk = ~clk;

    ps2_key_event_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .KEY0_CODE      (8'h1D),
        .KEY1_CODE      (8'h1C),
        .KEY2_CODE      (8'h1B),
        .KEY3_CODE      (8'h23)
    ) dut (
        .CLOCK_50          (clk),
        .reset             (rst),
        .received_data     (dat),
        .received_data_en  (en),
        .evt_valid         (evt_valid),
        .evt_ready         (rdy),
        .evt_code          (evt_code),
        .evt_extended      (evt_extended),
        .evt_break         (evt_break),
        .key_held          (key_held),
        .key_pressed_pulse (key_pressed_pulse),
        .overflow          (overflow),
        .protocol_error    (protocol_error)
    );

    // Reference model: pending prefix flags, a queue of {ext,brk,code}, held keys and sticky flags.
    logic [9:0] mq[$];
    logic [3:0] m_held;
    logic [3:0] m_pulse;
    logic       m_ovf;
    logic       m_perr;
    logic       m_ext;
    logic       m_brk;
    int         m_silent;
    logic [7:0] keys [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};

    logic [9:0] act_log[$];
    int         pulse_cnt [4] = '{0, 0, 0, 0};
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_held = '0; m_pulse = '0; m_ovf = 0; m_perr = 0;
        m_ext = 0; m_brk = 0; m_silent = 0;
    endtask

    task automatic model_step(input logic r, input logic e, input logic [7:0] b, input logic rd);
        logic       have;
        logic [9:0] ev;
        logic       pop;
        logic       full;
        logic       keep;
        if (r) begin
            model_clear();
            return;
        end
        pop     = (mq.size() != 0) && rd;
        full    = (mq.size() == DEPTH);
        have    = 0;
        ev      = '0;
        m_pulse = '0;
        if (e) begin
            m_silent = 0;
            if (!m_ext && !m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1})) begin
                    have = 1; ev = {2'b00, b};
                end
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b == 8'hE0) m_perr = 1;
                else begin have = 1; ev = {2'b10, b}; m_ext = 0; end
            end else begin
                if (b == 8'hE0 || b == 8'hF0) m_perr = 1;
                else begin have = 1; ev = {m_ext, 1'b1, b}; end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_silent++;
            if (m_silent >= TO) begin
                m_ext = 0; m_brk = 0; m_perr = 1; m_silent = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (have) begin
            keep = 1;
            for (int n = 0; n < 4; n++) begin
                if (!ev[9] && ev[7:0] == keys[n]) begin
                    if (ev[8]) m_held[n] = 0;
                    else if (m_held[n]) keep = 0;
                    else begin m_held[n] = 1; m_pulse[n] = 1; end
                end
            end
            if (keep) begin
                if (full && !pop) m_ovf = 1;
                else mq.push_back(ev);
            end
        end
    endtask

    // One clock cycle: drive inputs, log any accepted event, advance the model, compare on the next falling edge.
    task automatic tick(input logic r, input logic e, input logic [7:0] b, input logic rd);
        logic [9:0] exp_head;
        rst = r; en = e; dat = b; rdy = rd;
        if (!r && evt_valid && rd) act_log.push_back({evt_extended, evt_break, evt_code});
        model_step(r, e, b, rd);
        @(negedge clk);
        exp_head = (mq.size() != 0) ? mq[0] : 10'h000;
        chk("evt_head", {21'd0, evt_valid, evt_extended, evt_break, evt_code},
            {21'd0, (mq.size() != 0), exp_head});
        chk("key_held", {28'd0, key_held}, {28'd0, m_held});
        chk("key_pulse", {28'd0, key_pressed_pulse}, {28'd0, m_pulse});
        chk("flags", {30'd0, overflow, protocol_error}, {30'd0, m_ovf, m_perr});
        for (int n = 0; n < 4; n++) pulse_cnt[n] += int'(key_pressed_pulse[n]);
    endtask

    task automatic send(input logic [7:0] b, input logic rd);
        tick(1'b0, 1'b1, b, rd);
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, rd);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_log(input string nm, input int base, input logic [9:0] exp_q[$]);
        logic [31:0] a;
        chk({nm, "_count"}, act_log.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            a = (base + i < act_log.size()) ? {22'd0, act_log[base + i]} : 32'hDEAD;
            chk({nm, "_evt"}, a, {22'd0, exp_q[i]});
        end
    endtask

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23,
                              8'h15, 8'h75, 8'hAA, 8'hE1, 8'h00, 8'h29};

    initial begin
        int         base;
        int         p0;
        logic [9:0] e[$];
        logic [7:0] b;
        model_clear();
        @(negedge clk);
        do_reset();
        chk("rst_outputs", {20'd0, evt_valid, evt_code, evt_extended, evt_break, overflow, protocol_error},
            32'd0);
        chk("rst_keys", {24'd0, key_held, key_pressed_pulse}, 32'd0);

        // Plain tracked key with the consumer always ready.
        base = act_log.size(); p0 = pulse_cnt[1];
        send(8'h1C, 1'b1);
        idle(1, 1'b1);
        chk("plain_held_between", {28'd0, key_held}, 32'h2);
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b1);
        idle(3, 1'b1);
        e = '{10'h01C, 10'h11C};
        chk_log("plain", base, e);
        chk("plain_held_after", {28'd0, key_held}, 32'h0);
        chk("plain_pulses", pulse_cnt[1] - p0, 1);

        // Extended key: make and break carry ext=1 and never touch held state.
        base = act_log.size();
        send(8'hE0, 1'b1); send(8'h75, 1'b1);
        send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
        idle(3, 1'b1);
        e = '{10'h275, 10'h375};
        chk_log("ext", base, e);
        chk("ext_held", {28'd0, key_held}, 32'h0);

        // Typematic repeats of a held key are swallowed.
        base = act_log.size(); p0 = pulse_cnt[0];
        send(8'h1D, 1'b1); send(8'h1D, 1'b1); send(8'h1D, 1'b1);
        send(8'hF0, 1'b1); send(8'h1D, 1'b1);
        idle(3, 1'b1);
        e = '{10'h01D, 10'h11D};
        chk_log("repeat", base, e);
        chk("repeat_pulses", pulse_cnt[0] - p0, 1);

        // Backpressure: fifth event into a full queue is dropped.
        base = act_log.size();
        send(8'h15, 1'b0); send(8'h16, 1'b0); send(8'h26, 1'b0);
        send(8'h25, 1'b0); send(8'h2E, 1'b0);
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        idle(6, 1'b1);
        e = '{10'h015, 10'h016, 10'h026, 10'h025};
        chk_log("bp_drain", base, e);
        chk("bp_empty", {31'd0, evt_valid}, 32'd0);

        // Same traffic with a pop in the fifth byte's cycle: nothing lost.
        do_reset();
        base = act_log.size();
        send(8'h15, 1'b0); send(8'h16, 1'b0); send(8'h26, 1'b0);
        send(8'h25, 1'b0); send(8'h2E, 1'b1);
        idle(1, 1'b0);
        chk("bp_pop_no_overflow", {31'd0, overflow}, 32'd0);
        idle(6, 1'b1);
        e = '{10'h015, 10'h016, 10'h026, 10'h025, 10'h02E};
        chk_log("bp_pop_drain", base, e);

        // A byte landing in the expiry cycle beats the timeout.
        base = act_log.size();
        send(8'hE0, 1'b1);
        idle(TO - 1, 1'b1);
        send(8'h75, 1'b1);
        idle(2, 1'b1);
        chk("to_edge_no_error", {31'd0, protocol_error}, 32'd0);
        e = '{10'h275};
        chk_log("to_edge", base, e);

        // Prefix followed by silence: the timeout fires after exactly TO idle cycles.
        base = act_log.size();
        send(8'hE0, 1'b1);
        idle(TO - 1, 1'b1);
        chk("to_not_yet", {31'd0, protocol_error}, 32'd0);
        idle(1, 1'b1);
        chk("to_fired", {31'd0, protocol_error}, 32'd1);
        send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h1C, 1'b1);
        idle(2, 1'b1);
        e = '{10'h01C, 10'h11C};
        chk_log("to_after", base, e);

        // Double break prefix is illegal; the following byte is a make.
        do_reset();
        base = act_log.size();
        send(8'hF0, 1'b1); send(8'hF0, 1'b1); send(8'h1C, 1'b1);
        idle(2, 1'b1);
        chk("f0f0_error", {31'd0, protocol_error}, 32'd1);
        e = '{10'h01C};
        chk_log("f0f0", base, e);

        // Reset mid-sequence clears held keys, queue, prefix and sticky flags.
        send(8'h15, 1'b0); send(8'h16, 1'b0); send(8'h26, 1'b0);
        send(8'h25, 1'b0); send(8'h2E, 1'b0);
        send(8'h1D, 1'b0); send(8'hF0, 1'b0);
        chk("mid_held_before", {28'd0, key_held}, 32'h3);
        chk("mid_flags_before", {30'd0, overflow, protocol_error}, 32'h3);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mid_held_after", {28'd0, key_held}, 32'h0);
        chk("mid_empty", {31'd0, evt_valid}, 32'd0);
        chk("mid_flags_after", {30'd0, overflow, protocol_error}, 32'h0);
        base = act_log.size();
        send(8'h1C, 1'b1);
        idle(3, 1'b1);
        e = '{10'h01C};
        chk_log("mid", base, e);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                tick(1'b1, 1'b0, 8'h00, 1'b0);
            end else if ($urandom_range(0, 149) == 0) begin
                idle(TO + 3, $urandom_range(0, 1) == 1);
            end else begin
                b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : pool[$urandom_range(0, 11)];
                tick(1'b0, $urandom_range(0, 9) < 6, b, $urandom_range(0, 2) != 0);
            end
        end
        idle(8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
